// File: rtl/rv64_multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller and the
// instruction/data memories.
interface rv64_multicycle_controller_if;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;

  modport master (
    output imem_req,
    input  imem_ready,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ready
  );
endinterface

// File: rtl/rv64_multicycle_controller.sv
// Multicycle RV64I control FSM: owns the instruction register, sequences
// fetch/decode/exec/mem/writeback and traps on illegal opcodes or memory timeout.
module rv64_multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  rv64_multicycle_controller_if.master        mem,
  input  logic                                branch_cond,
  output logic [31:0]                         ir,
  output logic                                pc_we,
  output logic [1:0]                          pc_src,
  output logic                                reg_we,
  output logic [1:0]                          wb_sel,
  output logic                                alu_src_a,
  output logic                                alu_src_b,
  output logic                                instr_retired,
  output logic                                trap,
  output logic [2:0]                          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_IW     = 7'b0011011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int N_OPS = 11;
  localparam logic [N_OPS-1:0][6:0] LEGAL_OPS = {
    OP_R, OP_I, OP_RW, OP_IW, OP_LUI, OP_AUIPC,
    OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR
  };

  state_t            state_reg, state_next;
  logic [31:0]       ir_reg;
  logic [TO_W-1:0]   wait_reg, wait_next;

  logic [6:0]        opcode;
  logic [N_OPS-1:0]  legal_hit;
  logic              legal;
  logic              is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic              uses_rs2;

  assign opcode = ir_reg[6:0];

  genvar gi;
  generate
    for (gi = 0; gi < N_OPS; gi++) begin : g_legal
      assign legal_hit[gi] = (opcode == LEGAL_OPS[gi]);
    end
  endgenerate

  assign legal     = |legal_hit;
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign uses_rs2  = (opcode == OP_R) || (opcode == OP_RW) || is_branch;

  // State register; ir only loads on a completed fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      ir_reg    <= NOP_INSN;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (state_reg == S_FETCH && mem.imem_ready) begin
        ir_reg <= mem.imem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      S_FETCH: begin
        if (mem.imem_ready)               state_next = S_DECODE;
        else if (wait_reg == TIMEOUT_CNT) state_next = S_TRAP;
        else                              wait_next  = wait_reg + 1'b1;
      end
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_branch)                 state_next = S_FETCH;
        else if (is_load || is_store)  state_next = S_MEM;
        else                           state_next = S_WB;
      end
      S_MEM: begin
        if (mem.dmem_ready)               state_next = is_store ? S_FETCH : S_WB;
        else if (wait_reg == TIMEOUT_CNT) state_next = S_TRAP;
        else                              wait_next  = wait_reg + 1'b1;
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
    // Any state change restarts the wait count, so FETCH and MEM always begin at zero.
    if (state_next != state_reg) begin
      wait_next = '0;
    end
  end

  always_comb begin
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.dmem_we   = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 2'b00;
    reg_we        = 1'b0;
    wb_sel        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    instr_retired = 1'b0;
    trap          = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: mem.imem_req = 1'b1;
        S_EXEC: begin
          alu_src_a = is_auipc;
          alu_src_b = !uses_rs2;
          if (is_branch) begin
            pc_we         = 1'b1;
            pc_src        = branch_cond ? 2'b01 : 2'b00;
            instr_retired = 1'b1;
          end
        end
        S_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = is_store;
          if (is_store && mem.dmem_ready) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
          end
        end
        S_WB: begin
          reg_we        = 1'b1;
          pc_we         = 1'b1;
          instr_retired = 1'b1;
          if (is_load)                wb_sel = 2'b01;
          else if (is_jal || is_jalr) wb_sel = 2'b10;
          else if (is_lui)            wb_sel = 2'b11;
          if (is_jal)                 pc_src = 2'b01;
          else if (is_jalr)           pc_src = 2'b10;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign ir    = ir_reg;
  assign state = reset ? 3'd0 : state_reg;

endmodule

// File: tb/tb_rv64_multicycle_controller.sv
// Cycle-by-cycle scoreboard bench for the multicycle controller: each row drives
// one cycle of inputs and queues the full expected control vector for that cycle.
module tb_rv64_multicycle_controller;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LD    = 32'h0000_B103;
  localparam logic [31:0] BEQ   = 32'h0020_8463;
  localparam logic [31:0] JALR  = 32'h0000_80E7;
  localparam logic [31:0] SD    = 32'h0020_B023;
  localparam logic [31:0] ADD   = 32'h0020_80B3;
  localparam logic [31:0] AUIPC = 32'h0000_0097;
  localparam logic [31:0] LUI   = 32'h0000_10B7;
  localparam logic [31:0] JAL   = 32'h0080_006F;
  localparam logic [31:0] ADDIW = 32'h0010_809B;
  localparam logic [31:0] ADDW  = 32'h0020_80BB;
  localparam logic [31:0] BAD   = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        branch_cond;
  logic [31:0] ir;
  logic        pc_we, reg_we, alu_src_a, alu_src_b, instr_retired, trap;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  state;
  logic [15:0] obs;

  rv64_multicycle_controller_if mif ();

  rv64_multicycle_controller #(.MEM_TIMEOUT(255), .TO_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (mif),
    .branch_cond   (branch_cond),
    .ir            (ir),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .instr_retired (instr_retired),
    .trap          (trap),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state, mif.imem_req, mif.dmem_req, mif.dmem_we, pc_we, pc_src,
                reg_we, wb_sel, alu_src_a, alu_src_b, instr_retired, trap};

  typedef struct {
    logic        rst;
    logic        irdy;
    logic [31:0] rdata;
    logic        drdy;
    logic        bc;
    logic [15:0] exp;
  } row_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] mk(input logic [2:0] st, input logic ireq, input logic dreq,
                                     input logic dwe, input logic pcwe, input logic [1:0] pcsrc,
                                     input logic rwe, input logic [1:0] wbs, input logic a,
                                     input logic b, input logic ret, input logic trp);
    return {st, ireq, dreq, dwe, pcwe, pcsrc, rwe, wbs, a, b, ret, trp};
  endfunction

  function automatic logic [15:0] e_zero();   return 16'h0000; endfunction
  function automatic logic [15:0] e_fetch();  return mk(3'd0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic logic [15:0] e_decode(); return mk(3'd1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0); endfunction
  function automatic logic [15:0] e_trap();   return mk(3'd5, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1); endfunction
  function automatic logic [15:0] e_exec(input logic a, input logic b);
    return mk(3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, a, b, 0, 0);
  endfunction
  function automatic logic [15:0] e_wb(input logic [1:0] pcsrc, input logic [1:0] wbs);
    return mk(3'd4, 0, 0, 0, 1, pcsrc, 1, wbs, 0, 0, 1, 0);
  endfunction
  function automatic logic [15:0] e_mem(input logic we, input logic done_store);
    return mk(3'd3, 0, 1, we, done_store, 2'b00, 0, 2'b00, 0, 0, done_store, 0);
  endfunction

  function automatic row_t r(input logic rst, input logic irdy, input logic [31:0] rdata,
                             input logic drdy, input logic bc, input logic [15:0] e);
    row_t x;
    x.rst = rst; x.irdy = irdy; x.rdata = rdata; x.drdy = drdy; x.bc = bc; x.exp = e;
    return x;
  endfunction

  task automatic drive(input row_t rw);
    @(posedge clk);
    #1;
    reset           = rw.rst;
    mif.imem_ready  = rw.irdy;
    mif.imem_rdata  = rw.rdata;
    mif.dmem_ready  = rw.drdy;
    branch_cond     = rw.bc;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [15:0] got, want;
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(1, 1, ADDI, 1, 1, e_zero()));
    rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset cyc%0d got=%h want=%h", i, got, want); end
    end
    total++;
    if (ir !== NOP) begin bad++; $display("FAIL reset_ir got=%h want=%h", ir, NOP); end
    $display("txn reset: %0d cycles", rows.size());
  endtask

  task automatic test_addi();
    row_t rows[$];
    logic [15:0] got, want;
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(0, 1, ADDI, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b00, 2'b00)));
    rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL addi cyc%0d got=%h want=%h", i, got, want); end
      if (i == 2) begin
        total++;
        if (ir !== ADDI) begin bad++; $display("FAIL addi_ir got=%h want=%h", ir, ADDI); end
      end
    end
    $display("txn addi: %0d cycles", rows.size());
  endtask

  task automatic test_load_wait();
    row_t rows[$];
    logic [15:0] got, want;
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(0, 1, LD, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    for (int k = 0; k < 3; k++) rows.push_back(r(0, 0, 0, 0, 0, e_mem(0, 0)));
    rows.push_back(r(0, 0, 0, 1, 0, e_mem(0, 0)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b00, 2'b01)));
    rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL load cyc%0d got=%h want=%h", i, got, want); end
    end
    $display("txn load: %0d cycles", rows.size());
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [15:0] got, want;
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(0, 1, BEQ, 0, 1, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 1, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 1, mk(3'd2, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 0, 1, 0)));
    rows.push_back(r(0, 1, BEQ, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, mk(3'd2, 0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0, 1, 0)));
    rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL branch cyc%0d got=%h want=%h", i, got, want); end
    end
    $display("txn branch taken+not-taken: %0d cycles", rows.size());
  endtask

  task automatic test_jalr_store();
    row_t rows[$];
    logic [15:0] got, want;
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(0, 1, JALR, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b10, 2'b10)));
    rows.push_back(r(0, 1, SD, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_mem(1, 0)));
    rows.push_back(r(0, 0, 0, 1, 0, e_mem(1, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL jalr_store cyc%0d got=%h want=%h", i, got, want); end
    end
    $display("txn jalr+store: %0d cycles", rows.size());
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [15:0] got, want;
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(0, 1, ADD, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 0)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b00, 2'b00)));
    rows.push_back(r(0, 1, AUIPC, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(1, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b00, 2'b00)));
    rows.push_back(r(0, 1, LUI, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b00, 2'b11)));
    rows.push_back(r(0, 1, JAL, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b01, 2'b10)));
    rows.push_back(r(0, 1, ADDIW, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b00, 2'b00)));
    rows.push_back(r(0, 1, ADDW, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 0)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b00, 2'b00)));
    rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL b2b cyc%0d got=%h want=%h", i, got, want); end
    end
    $display("txn back-to-back add/auipc/lui/jal/addiw/addw: %0d cycles", rows.size());
  endtask

  task automatic test_illegal();
    row_t rows[$];
    logic [15:0] got, want;
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(0, 1, BAD, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    for (int k = 0; k < 4; k++) rows.push_back(r(0, 1, ADDI, 1, 1, e_trap()));
    rows.push_back(r(1, 1, ADDI, 1, 1, e_zero()));
    rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL illegal cyc%0d got=%h want=%h", i, got, want); end
    end
    total++;
    if (ir !== NOP) begin bad++; $display("FAIL illegal_reset_ir got=%h want=%h", ir, NOP); end
    $display("txn illegal opcode + reset recovery: %0d cycles", rows.size());
  endtask

  task automatic test_timeout();
    row_t rows[$];
    logic [15:0] got, want;
    // Fetch never answered: 256 FETCH cycles (count 0..255), then TRAP.
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    for (int k = 0; k < 256; k++) rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_trap()));
    rows.push_back(r(0, 1, ADDI, 0, 0, e_trap()));
    // Ready arriving exactly when the count hits the limit still completes.
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    for (int k = 0; k < 255; k++) rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    rows.push_back(r(0, 1, ADDI, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_wb(2'b00, 2'b00)));
    // Data memory never answers a load.
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(0, 1, LD, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    for (int k = 0; k < 256; k++) rows.push_back(r(0, 0, 0, 0, 0, e_mem(0, 0)));
    rows.push_back(r(0, 0, 0, 1, 0, e_trap()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL timeout cyc%0d got=%h want=%h", i, got, want); end
    end
    $display("txn timeouts fetch/edge/mem: %0d cycles", rows.size());
  endtask

  task automatic test_reset_in_mem();
    row_t rows[$];
    logic [15:0] got, want;
    rows.push_back(r(1, 0, 0, 0, 0, e_zero()));
    rows.push_back(r(0, 1, SD, 0, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_decode()));
    rows.push_back(r(0, 0, 0, 0, 0, e_exec(0, 1)));
    rows.push_back(r(0, 0, 0, 0, 0, e_mem(1, 0)));
    rows.push_back(r(1, 0, 0, 1, 0, e_zero()));
    rows.push_back(r(0, 0, 0, 1, 0, e_fetch()));
    rows.push_back(r(0, 0, 0, 0, 0, e_fetch()));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].exp);
      @(negedge clk);
      got = obs; want = exp_q.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_mem cyc%0d got=%h want=%h", i, got, want); end
    end
    $display("txn reset during MEM: %0d cycles", rows.size());
  endtask

  initial begin
    reset          = 1'b1;
    branch_cond    = 1'b0;
    mif.imem_ready = 1'b0;
    mif.imem_rdata = 32'h0;
    mif.dmem_ready = 1'b0;
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_jalr_store();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_in_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv64_multicycle_controller.md
Name: rv64_multicycle_controller

Overview:
- Control FSM that sequences the RV64I datapath over several cycles per instruction, replacing per-cycle combinational control.
- Owns the instruction register (ir) that feeds the immediate generator and decoders.
- Drives the PC, register-file, ALU-operand, writeback and memory strobes.
- Handshakes with the instruction and data memories; traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 255, maximum wait cycles in FETCH or MEM before entering TRAP (1..255)
- TO_W, 8, width of the wait counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  instruction register, to immediate generator and decoders
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ready  in  1  data access complete
- branch_cond  in  1  branch comparator result for current ir
- pc_we  out  1  PC update strobe
- pc_src  out  2  00 pc+4, 01 pc+imm, 10 alu result with bit0 cleared (JALR)
- reg_we  out  1  register-file write strobe
- wb_sel  out  2  00 alu, 01 load data, 10 pc+4, 11 imm (LUI)
- alu_src_a  out  1  0 rs1, 1 pc (AUIPC)
- alu_src_b  out  1  0 rs2, 1 imm
- instr_retired  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky fault flag
- state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (synchronous, while reset=1):
  - state=FETCH, ir=32'h00000013 (NOP), wait counter=0.
  - All outputs forced to 0 while reset=1.
  - First cycle after reset deasserts: imem_req=1.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir<=imem_rdata and go to DECODE. This can occur in the same cycle as the request.
- DECODE (1 cycle), on ir[6:0]:
  - Legal opcodes: 0110011, 0010011, 0111011, 0011011, 0110111, 0010111, 0000011, 0100011, 1100011, 1101111, 1100111. Go to EXEC.
  - Any other opcode: go to TRAP.
- EXEC (1 cycle):
  - alu_src_b=1 for all opcodes except 0110011, 0111011, 1100011.
  - alu_src_a=1 only for AUIPC.
  - BRANCH: pc_we=1, pc_src=branch_cond?01:00, instr_retired=1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - dmem_req=1, dmem_we=1 for STORE.
  - Hold until dmem_ready.
  - STORE: on dmem_ready, pc_we=1, pc_src=00, instr_retired=1, go to FETCH.
  - LOAD: on dmem_ready, go to WB.
- WB (1 cycle):
  - reg_we=1, pc_we=1, instr_retired=1, go to FETCH.
  - wb_sel: LOAD 01; JAL/JALR 10; LUI 11; else 00.
  - pc_src: JAL 01; JALR 10; else 00.
- Control outputs are combinational decodes of state, ir and handshake inputs. ir changes only in FETCH.
- pc_we and instr_retired assert exactly once per instruction, in the same cycle.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM while ready is low.
  - When it reaches MEM_TIMEOUT with ready still low, go to TRAP.
  - ready arriving in the cycle the count equals MEM_TIMEOUT: ready wins.
- TRAP:
  - trap=1; imem_req, dmem_req, pc_we and reg_we are 0.
  - Held until reset.
- Zero-wait latency in cycles: ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3.
- Reset mid-instruction: the next cycle is FETCH with no partial writes. pc_we and reg_we are 0 during reset.

Test Plan:
- Reset, then imem_ready=1 with addi (32'h00500093) -> states 0,1,2,4. alu_src_b=1 in EXEC. reg_we=pc_we=instr_retired=1 in WB, wb_sel=00. Back in FETCH on cycle 5.
- Load 32'h0000B103 with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0. WB wb_sel=01. 8 cycles total.
- beq 32'h00208463: branch_cond=1 -> EXEC pc_we=1, pc_src=01, reg_we never 1. Repeat with branch_cond=0 -> pc_src=00.
- jalr 32'h000080E7 -> WB reg_we=1, wb_sel=10, pc_src=10. Store 32'h0020B023 -> dmem_we=1, pc_we only at dmem_ready, reg_we never 1.
- ir=32'hFFFFFFFF -> DECODE then TRAP, trap=1. No reqs until reset. Reset returns state=0, ir=32'h00000013.
- imem_ready held low -> TRAP after 255 wait cycles. Ready asserted on cycle 255 -> no trap. Reset asserted in MEM -> dmem_req drops the same cycle, FETCH next.
